// File: rtl/micro_op_queue.sv
// Micro-op decoupling FIFO between the decoder/cracker and issue.
// Two-wide in-order enqueue, one-wide dequeue, flush, branch-class occupancy.
package micro_op_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  dst;
        logic [31:0] src0_val;
        logic [31:0] src1_val;
    } micro_op_t;

    localparam logic [7:0] m_nop  = 8'd0;
    localparam logic [7:0] m_ld   = 8'd1;
    localparam logic [7:0] m_st   = 8'd2;
    localparam logic [7:0] m_add  = 8'd3;
    localparam logic [7:0] m_sub  = 8'd4;
    localparam logic [7:0] M_JMIN = 8'd8;
    localparam logic [7:0] m_jnb  = 8'd9;
    localparam logic [7:0] m_jz   = 8'd10;
    localparam logic [7:0] m_jmp  = 8'd11;
    localparam logic [7:0] m_jne  = 8'd12;
    localparam logic [7:0] M_JMAX = 8'd13;

endpackage

module micro_op_queue
    import micro_op_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq0_valid,
    input  micro_op_t                  enq0_uop,
    input  logic                       enq1_valid,
    input  micro_op_t                  enq1_uop,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output micro_op_t                  deq_uop,
    input  logic                       deq_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     branch_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    micro_op_t         mem [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     bcount_q, bcount_d;

    logic              enq_fire;
    logic              enq_two;
    logic              deq_fire;
    logic [PW-1:0]     tail_p1;
    logic [CW-1:0]     n_enq;
    logic [CW-1:0]     n_deq;
    logic [CW-1:0]     br_enq;
    logic [CW-1:0]     br_deq;
    micro_op_t         head_uop;

    function automatic logic is_branch(input logic [7:0] op);
        return (op > M_JMIN) && (op < M_JMAX);
    endfunction

    always_comb begin
        head_uop  = mem[head_q];
        // Pairs are never split, so readiness demands room for two.
        enq_ready = count_q <= CW'(DEPTH - 2);
        deq_valid = count_q != '0;
        deq_uop   = deq_valid ? head_uop : '0;
        count        = count_q;
        branch_count = bcount_q;

        enq_fire = enq_ready && enq0_valid && !flush;
        enq_two  = enq_fire && enq1_valid;
        deq_fire = deq_valid && deq_ready && !flush;
        tail_p1  = tail_q + PW'(1);

        n_enq  = CW'(enq_fire) + CW'(enq_two);
        n_deq  = CW'(deq_fire);
        br_enq = CW'(enq_fire && is_branch(enq0_uop.opcode))
               + CW'(enq_two && is_branch(enq1_uop.opcode));
        br_deq = CW'(deq_fire && is_branch(head_uop.opcode));

        head_d   = head_q + PW'(n_deq);
        tail_d   = tail_q + PW'(n_enq);
        count_d  = count_q + n_enq - n_deq;
        bcount_d = bcount_q + br_enq - br_deq;

        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            bcount_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            bcount_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            bcount_q <= bcount_d;
        end
    end

    // Payload storage is never cleared; pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail_q] <= enq0_uop;
        end
        if (enq_two) begin
            mem[tail_p1] <= enq1_uop;
        end
    end

endmodule
